// File: rtl/alu_pkg.sv
// Shared ALU control codes and execution-unit state encoding.
// Optional feature macro: ALU_NOR_EN (adds the NOR op code).
package alu_pkg;

    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_SLT  = 4'b0111;
    localparam logic [3:0] ALU_SRL  = 4'b1001;
    localparam logic [3:0] ALU_SLTU = 4'b1111;
`ifdef ALU_NOR_EN
    localparam logic [3:0] ALU_NOR  = 4'b1100;
`endif

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

endpackage

// File: rtl/alu_exec_unit_comb.sv
// Single-cycle ALU datapath: result and signed overflow for one op code.
// Optional feature macro: ALU_NOR_EN (code 1100 computes ~(a | b)).
module alu_comb
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic             overflow
);

    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] diff;

    assign sum  = a + b;
    assign diff = a - b;

    // Select the op result; unknown codes behave as ADD.
    always_comb begin
        result   = sum;
        overflow = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
        case (op)
            ALU_AND:  begin result = a & b; overflow = 1'b0; end
            ALU_OR:   begin result = a | b; overflow = 1'b0; end
            ALU_SUB:  begin
                result   = diff;
                overflow = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
            end
            ALU_SLT:  begin
                result   = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
                overflow = 1'b0;
            end
            ALU_SLTU: begin
                result   = {{(WIDTH-1){1'b0}}, (a < b)};
                overflow = 1'b0;
            end
            // Only reached with a zero shift amount; nonzero shifts run iteratively.
            ALU_SRL:  begin result = a; overflow = 1'b0; end
`ifdef ALU_NOR_EN
            ALU_NOR:  begin result = ~(a | b); overflow = 1'b0; end
`endif
            default:  ;
        endcase
    end

endmodule

// File: rtl/alu_exec_unit.sv
// ALU execution unit: single-cycle logical/arithmetic ops and an iterative
// 1-bit-per-cycle SRL, with start/busy/done handshake and registered flags.
// Optional feature macro: ALU_NOR_EN (code 1100 computes ~(a | b)).
module alu_exec_unit
    import alu_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [3:0]         aluControl,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic [SHAMT_W-1:0] shamt,
    output logic               busy,
    output logic               done,
    output logic [WIDTH-1:0]   result,
    output logic               zero,
    output logic               overflow
);

    state_t             state;
    logic [WIDTH-1:0]   shreg;
    logic [SHAMT_W-1:0] cnt;
    logic [WIDTH-1:0]   comb_result;
    logic               comb_ovf;

    alu_comb #(.WIDTH(WIDTH)) u_comb (
        .op       (aluControl),
        .a        (a),
        .b        (b),
        .result   (comb_result),
        .overflow (comb_ovf)
    );

    // Control FSM, shifter, counter and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            result   <= '0;
            zero     <= 1'b0;
            overflow <= 1'b0;
            shreg    <= '0;
            cnt      <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (aluControl == ALU_SRL && shamt != '0) begin
                            shreg <= a;
                            cnt   <= shamt;
                            busy  <= 1'b1;
                            state <= SHIFT;
                        end else begin
                            result   <= comb_result;
                            zero     <= (comb_result == '0);
                            overflow <= comb_ovf;
                            done     <= 1'b1;
                        end
                    end
                end
                SHIFT: begin
                    shreg <= shreg >> 1;
                    cnt   <= cnt - SHAMT_W'(1);
                    // Final step writes the last shifted value directly to result.
                    if (cnt == SHAMT_W'(1)) begin
                        result   <= shreg >> 1;
                        zero     <= ((shreg >> 1) == '0);
                        overflow <= 1'b0;
                        done     <= 1'b1;
                        busy     <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
